data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Param ADDR_WIDTH, default 32: byte-address width.
REQ-002 Param DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 4.
REQ-003 Param BASE_ADDR, default 32'h0000_1000: byte address of word 0; 4-byte aligned.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1: asynchronous active-low reset.
REQ-006 Port req_valid  in  1: request present.
REQ-007 Port req_ready  out  1: block accepts request this cycle.
REQ-008 Port req_we  in  1: 1 = store, 0 = load.
REQ-009 Port req_funct3  in  3: RISC-V size/sign code.
REQ-010 Port req_addr  in  ADDR_WIDTH: byte address.
REQ-011 Port req_wdata  in  32: store data, right-aligned.
REQ-012 Port rsp_valid  out  1: response present.
REQ-013 Port rsp_ready  in  1: consumer takes response.
REQ-014 Port rsp_rdata  out  32: load result, extended; 0 for stores and errors.
REQ-015 Port rsp_err  out  1: access fault.

Function
REQ-016 A request is accepted when req_valid and req_ready are both high on a rising edge; a response is consumed when rsp_valid and rsp_ready are both high.
REQ-017 Two states: IDLE (no response held) and RESP (response held); IDLE->RESP on accept; RESP->IDLE on consume without accept; RESP->RESP on simultaneous consume and accept.
REQ-018 req_ready = (state==IDLE) | rsp_ready; combinational, no other dependence.
REQ-019 Every accepted request, store included, produces exactly one response, asserted rsp_valid the cycle after acceptance.
REQ-020 rsp_valid, rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
REQ-021 Word index = (req_addr - BASE_ADDR) >> 2; range fault when req_addr < BASE_ADDR or req_addr >= BASE_ADDR + 4*DEPTH_WORDS.
REQ-022 funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; loads sign- or zero-extend accordingly; 011, 110, 111, and 100/101 with req_we=1, are encoding faults.
REQ-023 Stores write only the addressed byte lanes (addr[1:0] selects lane; SH uses lanes {addr[1],0}+1..0); other lanes unchanged.
REQ-024 Load data is sampled from memory at acceptance; a load accepted the cycle after a store to the same word returns the stored data.
REQ-025 Any fault: no memory write, rsp_err=1, rsp_rdata=0.

Reset
REQ-026 While rst_n=0: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, regardless of clk.
REQ-027 Reset mid-transaction discards the held response; no write is performed for a request presented during reset.
REQ-028 Memory array contents are not reset.

Configuration
REQ-029 Macro DATA_MEM_MISALIGN_TRAP_EN: defined -> halfword access with addr[0]=1 or word access with addr[1:0]!=0 is a fault per REQ-025.
REQ-030 Macro absent -> misaligned addresses are forced aligned (low bits cleared to the access size) and never fault.

Verification
REQ-031 SW 0x1000 <- 0xDEADBEEF, then LW 0x1000 -> rsp_valid next cycle, rdata 0xDEADBEEF, err 0.
REQ-032 SB 0x1002 <- 0x80, then LB 0x1002 -> 0xFFFFFF80; LBU 0x1002 -> 0x00000080; LW 0x1000 -> 0xDE80BEEF.
REQ-033 LW 0x0FFC and LW 0x1000+4*DEPTH_WORDS -> err 1, rdata 0; SW to same addresses leaves memory unchanged.
REQ-034 rsp_ready held 0 for 3 cycles after a load -> req_ready 0, response stable; rsp_ready 1 with new req_valid -> back-to-back accept, one response per request in order.
REQ-035 LW 0x1002: with DATA_MEM_MISALIGN_TRAP_EN -> err 1, rdata 0; without -> err 0, rdata = word at 0x1000.
REQ-036 rst_n pulsed low while rsp_valid=1 -> rsp_valid 0 immediately, req_ready 1 after release, memory data retained.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with a RISC-V style load/store front end and a one-deep response register.
// Optional build macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of aligning them.
module data_mem_lsu #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e          state_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      wordIdx;
  logic                  rangeFault;
  logic                  encFault;
  logic                  alignFault;
  logic                  fault;
  logic                  isByte;
  logic                  isHalf;
  logic                  isWord;
  logic [1:0]            lane;
  logic [3:0]            byteEn;
  logic [31:0]           wdataRep;
  logic [31:0]           shifted;
  logic [31:0]           loadData;
  logic [31:0]           rsp_rdata_d;

  assign req_ready = (state_q == IDLE) | rsp_ready;
  assign accept    = req_valid & req_ready;

  // Offset above the base also serves as the upper-bound test: any bit above the array span means out of range.
  assign offset     = req_addr - BASE_ADDR;
  assign wordIdx    = offset[IDX_W+1:2];
  assign rangeFault = (req_addr < BASE_ADDR) | (|offset[ADDR_WIDTH-1:IDX_W+2]);

  always_comb begin
    isByte     = (req_funct3[1:0] == 2'b00);
    isHalf     = (req_funct3[1:0] == 2'b01);
    isWord     = (req_funct3[1:0] == 2'b10);
    encFault   = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_funct3[1] | req_we));
    lane       = isWord ? 2'b00 : (isHalf ? {offset[1], 1'b0} : offset[1:0]);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    alignFault = (isHalf & offset[0]) | (isWord & (|offset[1:0]));
`else
    alignFault = 1'b0;
`endif
    fault      = rangeFault | encFault | alignFault;

    byteEn   = 4'b0000;
    wdataRep = req_wdata;
    if (isByte) begin
      byteEn   = 4'b0001 << lane;
      wdataRep = {4{req_wdata[7:0]}};
    end else if (isHalf) begin
      byteEn   = 4'b0011 << lane;
      wdataRep = {2{req_wdata[15:0]}};
    end else if (isWord) begin
      byteEn   = 4'b1111;
    end

    shifted  = mem_q[wordIdx] >> {lane, 3'b000};
    loadData = shifted;
    if (isByte) begin
      loadData = {{24{~req_funct3[2] & shifted[7]}}, shifted[7:0]};
    end else if (isHalf) begin
      loadData = {{16{~req_funct3[2] & shifted[15]}}, shifted[15:0]};
    end
    rsp_rdata_d = (req_we | fault) ? 32'h0 : loadData;
  end

  // Response FSM: a new accept always overwrites, so a consume+accept in one cycle stays in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      state_q     <= RESP;
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= fault;
    end else if (rsp_valid_q & rsp_ready) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end
  end

  // Storage is not reset; rst_n only blocks writes for requests that arrive while reset is held.
  always_ff @(posedge clk) begin
    if (accept & rst_n & req_we & ~fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem_q[wordIdx][8*b +: 8] <= wdataRep[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed, table-driven bench for data_mem_lsu with hand sequences for back-pressure and mid-transaction reset.
module tb_data_mem_lsu;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  data_mem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Drive one request at the falling edge, let it be accepted, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expData, input logic expErr);
    vecs.push_back('{we, f3, addr, wdata, expData, expErr});
  endtask

  initial begin
    addVec(1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0,        0);
    addVec(0, 3'b010, 32'h1000, 32'h0,        32'hDEADBEEF, 0);
    addVec(1, 3'b000, 32'h1002, 32'h00000080, 32'h0,        0);
    addVec(0, 3'b000, 32'h1002, 32'h0,        32'hFFFFFF80, 0);
    addVec(0, 3'b100, 32'h1002, 32'h0,        32'h00000080, 0);
    addVec(0, 3'b010, 32'h1000, 32'h0,        32'hDE80BEEF, 0);
    addVec(1, 3'b010, 32'h1FFC, 32'hCAFEF00D, 32'h0,        0);
    addVec(0, 3'b010, 32'h0FFC, 32'h0,        32'h0,        1);
    addVec(0, 3'b010, 32'h2000, 32'h0,        32'h0,        1);
    addVec(1, 3'b010, 32'h0FFC, 32'h12345678, 32'h0,        1);
    addVec(1, 3'b010, 32'h2000, 32'h87654321, 32'h0,        1);
    addVec(0, 3'b010, 32'h1FFC, 32'h0,        32'hCAFEF00D, 0);
    addVec(0, 3'b010, 32'h1000, 32'h0,        32'hDE80BEEF, 0);
    addVec(1, 3'b010, 32'h1004, 32'h11223344, 32'h0,        0);
    addVec(1, 3'b001, 32'h1006, 32'h5555ABCD, 32'h0,        0);
    addVec(0, 3'b010, 32'h1004, 32'h0,        32'hABCD3344, 0);
    addVec(0, 3'b001, 32'h1006, 32'h0,        32'hFFFFABCD, 0);
    addVec(0, 3'b101, 32'h1006, 32'h0,        32'h0000ABCD, 0);
    addVec(0, 3'b001, 32'h1004, 32'h0,        32'h00003344, 0);
    addVec(0, 3'b000, 32'h1007, 32'h0,        32'hFFFFFFAB, 0);
    addVec(0, 3'b100, 32'h1005, 32'h0,        32'h00000033, 0);
    addVec(0, 3'b011, 32'h1000, 32'h0,        32'h0,        1);
    addVec(0, 3'b110, 32'h1000, 32'h0,        32'h0,        1);
    addVec(0, 3'b111, 32'h1000, 32'h0,        32'h0,        1);
    addVec(1, 3'b100, 32'h1000, 32'h000000FF, 32'h0,        1);
    addVec(1, 3'b101, 32'h1000, 32'h0000FFFF, 32'h0,        1);
    addVec(0, 3'b010, 32'h1000, 32'h0,        32'hDE80BEEF, 0);
    addVec(0, 3'b010, 32'h1002, 32'h0,        Trap ? 32'h0 : 32'hDE80BEEF, Trap);
    addVec(0, 3'b001, 32'h1005, 32'h0,        Trap ? 32'h0 : 32'h00003344, Trap);

    // Outputs must be idle while reset is held, independent of clock edges.
    #1;
    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_err",   {31'b0, rsp_err},   32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata,          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle req_ready", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      checkOutput($sformatf("vec%0d rsp_rdata", i), rsp_rdata,          vecs[i].expData);
      checkOutput($sformatf("vec%0d rsp_err", i),   {31'b0, rsp_err},   {31'b0, vecs[i].expErr});
    end
    @(posedge clk);
    #1;
    checkOutput("drain rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Back-pressure: response must hold for 3 stalled cycles while a second request waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    applyStimulus(0, 3'b010, 32'h1004, 32'h0);
    checkOutput("bp first rdata", rsp_rdata, 32'hABCD3344);
    req_valid = 1'b1;
    req_addr  = 32'h1000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp hold%0d req_ready", c), {31'b0, req_ready}, 32'd0);
      checkOutput($sformatf("bp hold%0d rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
      checkOutput($sformatf("bp hold%0d rsp_rdata", c), rsp_rdata,          32'hABCD3344);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp release req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp second rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("bp second rsp_rdata", rsp_rdata,          32'hDE80BEEF);
    @(negedge clk);
    req_addr = 32'h1FFC;
    @(posedge clk);
    #1;
    checkOutput("bp third rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("bp done rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset while a response is held, with a store presented during reset that must not land.
    @(negedge clk);
    rsp_ready = 1'b0;
    applyStimulus(0, 3'b010, 32'h1000, 32'h0);
    checkOutput("rst held rsp_valid", {31'b0, rsp_valid}, 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h1000;
    req_wdata  = 32'h0BADF00D;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst async rsp_rdata", rsp_rdata,          32'd0);
    checkOutput("rst async rsp_err",   {31'b0, rsp_err},   32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    #1;
    checkOutput("rst release req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst release rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    applyStimulus(0, 3'b010, 32'h1000, 32'h0);
    checkOutput("rst retained rdata", rsp_rdata,          32'hDE80BEEF);
    checkOutput("rst retained err",   {31'b0, rsp_err},   32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
